// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state and grant encodings shared by the memory arbiter and its grant picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef logic [1:0] grant_t;

    localparam grant_t GNT_NONE = 2'd0;
    localparam grant_t GNT_INST = 2'd1;
    localparam grant_t GNT_DATA = 2'd2;

    function automatic state_t grant_state(input grant_t g);
        return (g == GNT_INST) ? INST : (g == GNT_DATA) ? DATA : IDLE;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational grant choice between the fetch and data ports.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the port not granted last; otherwise data always wins ties.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   inst_elig,
    input  logic   data_elig,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  grant_t last_grant,
`endif
    output grant_t grant
);

    logic tie_to_inst;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_to_inst = (last_grant == GNT_DATA);
`else
    assign tie_to_inst = 1'b0;
`endif

    always_comb begin
        grant = (inst_elig && data_elig) ? (tie_to_inst ? GNT_INST : GNT_DATA) :
                data_elig                ? GNT_DATA :
                inst_elig                ? GNT_INST : GNT_NONE;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access, one transaction at a time.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; the default build gives data fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_BITWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_ce_i,
    input  logic [WORD_BITWIDTH-1:0] inst_addr_i,
    output logic [WORD_BITWIDTH-1:0] inst_data_o,
    output logic                     inst_valid_o,
    output logic                     inst_stall_o,
    input  logic                     data_ce_i,
    input  logic                     data_we_i,
    input  logic [WORD_BITWIDTH-1:0] data_addr_i,
    input  logic [WORD_BITWIDTH-1:0] data_wdata_i,
    output logic [WORD_BITWIDTH-1:0] data_rdata_o,
    output logic                     data_valid_o,
    output logic                     data_stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [WORD_BITWIDTH-1:0] mem_addr_o,
    output logic [WORD_BITWIDTH-1:0] mem_wdata_o,
    input  logic [WORD_BITWIDTH-1:0] mem_rdata_i,
    input  logic                     mem_ack_i
);

    state_t state, state_next;
    grant_t grant;
    logic   inst_elig, data_elig, granting, inst_done, data_done;

    // A port completing this cycle still shows the consumed request on ce_i.
    assign inst_elig = inst_ce_i && !inst_valid_o;
    assign data_elig = data_ce_i && !data_valid_o;
    assign inst_stall_o = inst_ce_i && !inst_valid_o;
    assign data_stall_o = data_ce_i && !data_valid_o;

    assign granting  = (state == IDLE) && (grant != GNT_NONE);
    assign inst_done = (state == INST) && mem_ack_i;
    assign data_done = (state == DATA) && mem_ack_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_t last_grant;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= GNT_INST;
        else if (granting)
            last_grant <= grant;
    end

    arb_pick u_pick (
        .inst_elig  (inst_elig),
        .data_elig  (data_elig),
        .last_grant (last_grant),
        .grant      (grant)
    );
`else
    arb_pick u_pick (
        .inst_elig (inst_elig),
        .data_elig (data_elig),
        .grant     (grant)
    );
`endif

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end

    always_comb begin
        state_next = (state == IDLE) ? grant_state(grant) : (mem_ack_i ? IDLE : state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            inst_data_o  <= '0;
            data_rdata_o <= '0;
            inst_valid_o <= 1'b0;
            data_valid_o <= 1'b0;
        end else begin
            inst_valid_o <= inst_done;
            data_valid_o <= data_done;
            if (granting) begin
                mem_req_o   <= 1'b1;
                mem_addr_o  <= (grant == GNT_DATA) ? data_addr_i : inst_addr_i;
                mem_we_o    <= (grant == GNT_DATA) && data_we_i;
                mem_wdata_o <= (grant == GNT_DATA) ? data_wdata_i : '0;
            end else if (inst_done || data_done) begin
                mem_req_o <= 1'b0;
            end
            if (inst_done)
                inst_data_o <= mem_rdata_i;
            // mem_we_o still describes the transaction being acknowledged.
            if (data_done && !mem_we_o)
                data_rdata_o <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks against a behavioural memory responder with a result scoreboard.
module tb_mem_arbiter;

    localparam int W = 32;

    typedef struct {
        bit           is_data;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inst_ce_i, data_ce_i, data_we_i, mem_ack_i;
    logic [W-1:0] inst_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
    logic [W-1:0] inst_data_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    logic         inst_valid_o, inst_stall_o, data_valid_o, data_stall_o, mem_req_o, mem_we_o;

    exp_t         exp_q[$];
    logic [W-1:0] grant_q[$];
    logic [W-1:0] last_rd;
    int           checks = 0;
    int           errors = 0;
    int           ack_delay = 0;
    int           wait_cnt = 0;
    bit           ack_en = 1'b1;
    bit           force_ack = 1'b0;

    mem_arbiter #(.WORD_BITWIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_ce_i    (inst_ce_i),
        .inst_addr_i  (inst_addr_i),
        .inst_data_o  (inst_data_o),
        .inst_valid_o (inst_valid_o),
        .inst_stall_o (inst_stall_o),
        .data_ce_i    (data_ce_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_valid_o (data_valid_o),
        .data_stall_o (data_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: acks ack_delay cycles after the first cycle a request is seen.
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o && ack_en && wait_cnt >= ack_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_word(mem_addr_o);
                wait_cnt    = 0;
            end else begin
                mem_ack_i = force_ack;
                wait_cnt  = mem_req_o ? wait_cnt + 1 : 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", mem_req_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", mem_we_o); end
        checks++; if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin errors++; $display("FAIL rst_mem: got %h/%h expected 0/0", mem_addr_o, mem_wdata_o); end
        checks++; if (inst_data_o !== '0 || data_rdata_o !== '0) begin errors++; $display("FAIL rst_data: got %h/%h expected 0/0", inst_data_o, data_rdata_o); end
        checks++; if (inst_valid_o !== 1'b0 || data_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b%b expected 00", inst_valid_o, data_valid_o); end
        last_rd = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch;
        ack_delay   = 0;
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h100;
        exp_q.push_back(exp_t'{1'b0, 32'h0050_0093});
        @(negedge clk);
        checks++; if (inst_stall_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_c0: got stall %b req %b expected 1 0", inst_stall_o, mem_req_o); end
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL fetch_c1_req: got %b %h expected 1 00000100", mem_req_o, mem_addr_o); end
        checks++; if (mem_we_o !== 1'b0 || mem_wdata_o !== '0) begin errors++; $display("FAIL fetch_c1_we: got %b %h expected 0 0", mem_we_o, mem_wdata_o); end
        checks++; if (inst_stall_o !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_c1_stall: got %b %b expected 1 0", inst_stall_o, inst_valid_o); end
        tick();
        @(negedge clk);
        begin
            exp_t e = exp_q.pop_front();
            checks++; if (inst_valid_o !== 1'b1 || e.is_data || inst_data_o !== e.data) begin errors++; $display("FAIL fetch_c2_data: got valid %b data %h expected 1 %h", inst_valid_o, inst_data_o, e.data); end
        end
        checks++; if (inst_stall_o !== 1'b0) begin errors++; $display("FAIL fetch_c2_stall: got %b expected 0", inst_stall_o); end
        tick();
        inst_ce_i = 1'b0;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_c3: got valid %b req %b expected 0 0", inst_valid_o, mem_req_o); end
        tick();
    endtask

    task automatic test_collision;
        int n;
        ack_delay   = 1;
        data_ce_i   = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h2000;
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h104;
        exp_q.push_back(exp_t'{1'b1, mem_word(32'h2000)});
        exp_q.push_back(exp_t'{1'b0, mem_word(32'h104)});
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2000) begin errors++; $display("FAIL coll_first: got %b %h expected 1 00002000", mem_req_o, mem_addr_o); end
        checks++; if (data_stall_o !== 1'b1 || inst_stall_o !== 1'b1) begin errors++; $display("FAIL coll_stalls: got %b %b expected 1 1", data_stall_o, inst_stall_o); end
        n = 0;
        while (data_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        begin
            exp_t e = exp_q.pop_front();
            checks++; if (data_valid_o !== 1'b1 || !e.is_data || data_rdata_o !== e.data) begin errors++; $display("FAIL coll_load: got valid %b data %h expected 1 %h", data_valid_o, data_rdata_o, e.data); end
            last_rd = e.data;
        end
        checks++; if (data_stall_o !== 1'b0 || inst_stall_o !== 1'b1) begin errors++; $display("FAIL coll_valid_stalls: got %b %b expected 0 1", data_stall_o, inst_stall_o); end
        tick();
        data_ce_i = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104 || mem_we_o !== 1'b0) begin errors++; $display("FAIL coll_second: got %b %h %b expected 1 00000104 0", mem_req_o, mem_addr_o, mem_we_o); end
        n = 0;
        while (inst_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        begin
            exp_t e = exp_q.pop_front();
            checks++; if (inst_valid_o !== 1'b1 || e.is_data || inst_data_o !== e.data) begin errors++; $display("FAIL coll_fetch: got valid %b data %h expected 1 %h", inst_valid_o, inst_data_o, e.data); end
        end
        tick();
        inst_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_store;
        ack_delay    = 3;
        data_ce_i    = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h40;
        data_wdata_i = 32'hDEAD_BEEF;
        exp_q.push_back(exp_t'{1'b1, last_rd});
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_issue: got %b %b %h %h expected 1 1 00000040 deadbeef", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
        tick();
        data_addr_i  = 32'h999;
        data_wdata_i = '0;
        data_we_i    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_wdata_o !== 32'hDEAD_BEEF || data_valid_o !== 1'b0) begin errors++; $display("FAIL store_hold%0d: got %b %b %h %h v%b expected 1 1 00000040 deadbeef v0", i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, data_valid_o); end
        end
        @(negedge clk);
        begin
            exp_t e = exp_q.pop_front();
            checks++; if (data_valid_o !== 1'b1 || !e.is_data || data_rdata_o !== e.data) begin errors++; $display("FAIL store_done: got valid %b rdata %h expected 1 %h", data_valid_o, data_rdata_o, e.data); end
        end
        tick();
        data_ce_i = 1'b0;
        @(negedge clk);
        checks++; if (data_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL store_pulse: got valid %b req %b expected 0 0", data_valid_o, mem_req_o); end
        tick();
    endtask

    task automatic test_ce_drop;
        int n;
        ack_delay   = 2;
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h200;
        exp_q.push_back(exp_t'{1'b0, mem_word(32'h200)});
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin errors++; $display("FAIL drop_issue: got %b %h expected 1 00000200", mem_req_o, mem_addr_o); end
        tick();
        inst_ce_i   = 1'b0;
        inst_addr_i = 32'h300;
        n = 0;
        while (inst_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        begin
            exp_t e = exp_q.pop_front();
            checks++; if (inst_valid_o !== 1'b1 || e.is_data || inst_data_o !== e.data) begin errors++; $display("FAIL drop_done: got valid %b data %h expected 1 %h", inst_valid_o, inst_data_o, e.data); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL drop_quiet%0d: got req %b valid %b expected 0 0", i, mem_req_o, inst_valid_o); end
        end
        tick();
    endtask

    task automatic test_reset_mid;
        ack_en      = 1'b0;
        data_ce_i   = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h300;
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin errors++; $display("FAIL rmid_issue: got %b %h expected 1 00000300", mem_req_o, mem_addr_o); end
        tick();
        rst       = 1'b1;
        data_ce_i = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b0 || data_valid_o !== 1'b0 || mem_addr_o !== '0 || data_rdata_o !== '0) begin errors++; $display("FAIL rmid_reset: got req %b valid %b addr %h rdata %h expected 0 0 0 0", mem_req_o, data_valid_o, mem_addr_o, data_rdata_o); end
        rst       = 1'b0;
        force_ack = 1'b1;
        last_rd   = '0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b0 || data_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_late_ack: got req %b valid %b%b expected 0 00", mem_req_o, data_valid_o, inst_valid_o); end
        force_ack = 1'b0;
        ack_en    = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_back_to_back;
        logic         prev;
        int           n, got;
        logic [W-1:0] want;
        ack_delay = 0;
        grant_q   = '{32'h800, 32'h900, 32'h800, 32'h900};
        data_ce_i   = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h800;
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h900;
        prev = 1'b0;
        n    = 0;
        got  = 0;
        while (got < 4 && n < 60) begin
            @(negedge clk);
            if (mem_req_o === 1'b1 && prev !== 1'b1) begin
                want = grant_q.pop_front();
                checks++; if (mem_addr_o !== want) begin errors++; $display("FAIL b2b_grant%0d: got %h expected %h", got, mem_addr_o, want); end
                got++;
            end
            prev = mem_req_o;
            n++;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d grants expected 4", got); end
        tick();
        data_ce_i = 1'b0;
        inst_ce_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", mem_req_o); end
        tick();
    endtask

    task automatic test_tie_after_data;
        int           n;
        logic [W-1:0] first;
        ack_delay   = 1;
        data_ce_i   = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'hA00;
        exp_q.push_back(exp_t'{1'b1, mem_word(32'hA00)});
        n = 0;
        @(negedge clk);
        while (data_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        begin
            exp_t e = exp_q.pop_front();
            checks++; if (data_valid_o !== 1'b1 || !e.is_data || data_rdata_o !== e.data) begin errors++; $display("FAIL tie_load: got valid %b data %h expected 1 %h", data_valid_o, data_rdata_o, e.data); end
        end
        tick();
        data_ce_i = 1'b0;
        tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first = 32'hC00;
`else
        first = 32'hB00;
`endif
        data_ce_i   = 1'b1;
        data_addr_i = 32'hB00;
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'hC00;
        tick();
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== first) begin errors++; $display("FAIL tie_grant: got %b %h expected 1 %h", mem_req_o, mem_addr_o, first); end
        tick();
        data_ce_i = 1'b0;
        inst_ce_i = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst          = 1'b1;
        inst_ce_i    = 1'b0;
        inst_addr_i  = '0;
        data_ce_i    = 1'b0;
        data_we_i    = 1'b0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        test_reset();
        test_fetch();
        test_collision();
        test_store();
        test_ce_drop();
        test_reset_mid();
        test_back_to_back();
        test_tie_after_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
